// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the data-memory initiator.
//   - request size encodings
//   - controller state enum
//   - bit position of the word index within a byte address
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WORD_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_access_master_if.sv
// mem_access_master_if: request/response handshake plus word-only memory bus.
//   master modport: the initiator (mem_access_master)
//   slave  modport: the core pipeline / memory side
//   req_*  : load/store request from execute stage
//   rsp_*  : response back to the core
//   Adr/MWD/MWR/MOE/MRD : data-memory port (word index, write data,
//                         write strobe, output enable, read data)
interface mem_access_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] Adr;
    logic [31:0]       MWD;
    logic              MWR;
    logic              MOE;
    logic [31:0]       MRD;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, MRD,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Adr, MWD, MWR, MOE
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, MRD,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Adr, MWD, MWR, MOE
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for sub-word accesses.
//   addr_lo     : byte offset within the word
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   rdata       : word read from memory
//   wdata       : right-aligned store data
//   load_data   : extracted and extended load result
//   merge_data  : rdata with the store lanes replaced by wdata
import mem_access_pkg::*;

module mem_lane_align (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merge_data = rdata;
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merge_data = rdata;
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_master.sv
// mem_access_master: initiator side of the data-memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_access_master_if.master (request, response, memory bus)
//   Optional MEM_ACCESS_PERF_EN adds load_cnt/store_cnt/err_cnt outputs
//   counting response handshakes.
// One request in flight; byte/half stores are done as read-modify-write.
import mem_access_pkg::*;

module mem_access_master #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_master_if.master bus
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [15:0]         load_cnt,
    output logic [15:0]         store_cnt,
    output logic [7:0]          err_cnt
`endif
);
    localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       mwd_q, mwd_d;
    logic              mwr_q, mwr_d;
    logic              moe_q, moe_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [ADDR_W-1:0] word_idx;
    logic              req_err;
    logic              accept;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign word_idx = {2'b00, bus.req_addr[ADDR_W-1:WORD_LSB]};
    assign accept   = bus.req_valid && req_ready_q;

    always_comb begin
        req_err = (word_idx >= MEM_WORDS_L);
        case (bus.req_size)
            SZ_BYTE: ;
            SZ_HALF: if (bus.req_addr[0])            req_err = 1'b1;
            SZ_WORD: if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    mem_lane_align u_align (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata       (bus.MRD),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        adr_d       = adr_q;
        mwd_d       = mwd_q;
        mwr_d       = mwr_q;
        moe_d       = moe_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    addr_lo_d   = bus.req_addr[1:0];
                    size_d      = bus.req_size;
                    unsigned_d  = bus.req_unsigned;
                    wdata_d     = bus.req_wdata;
                    rsp_rdata_d = '0;
                    rsp_err_d   = req_err;
                    if (req_err) begin
                        // Rejected requests leave the memory bus untouched.
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        adr_d = word_idx;
                        if (!bus.req_we) begin
                            moe_d   = 1'b1;
                            state_d = ST_RD;
                        end else if (bus.req_size == SZ_WORD) begin
                            mwd_d   = bus.req_wdata;
                            mwr_d   = 1'b1;
                            state_d = ST_WR;
                        end else begin
                            moe_d   = 1'b1;
                            state_d = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                moe_d       = 1'b0;
                rsp_rdata_d = load_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RMW_RD: begin
                moe_d   = 1'b0;
                mwd_d   = merge_data;
                mwr_d   = 1'b1;
                state_d = ST_WR;
            end
            ST_WR: begin
                mwr_d       = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            adr_q       <= '0;
            mwd_q       <= '0;
            mwr_q       <= 1'b0;
            moe_q       <= 1'b0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            adr_q       <= adr_d;
            mwd_q       <= mwd_d;
            mwr_q       <= mwr_d;
            moe_q       <= moe_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.Adr       = adr_q;
    assign bus.MWD       = mwd_q;
    assign bus.MWR       = mwr_q;
    assign bus.MOE       = moe_q;

`ifdef MEM_ACCESS_PERF_EN
    logic        we_q, we_d;
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        we_d        = (state_q == ST_IDLE && accept) ? bus.req_we : we_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (state_q == ST_RESP && bus.rsp_ready) begin
            if (rsp_err_q)  err_cnt_d   = err_cnt_q + 8'd1;
            else if (we_q)  store_cnt_d = store_cnt_q + 16'd1;
            else            load_cnt_d  = load_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            we_q        <= we_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif
endmodule
